// File: rtl/duck_pkg.sv
// Shared types and constants for the duck palette arbiter: the 16-entry
// colour palette, the RGB nibble struct and the default colour-key index.
package duck_pkg;

  typedef struct packed {
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;
  } rgb12_t;

  localparam int unsigned DUCK_TRANSP_INDEX = 6;

  // Entry i lives at DUCK_PALETTE[i]; the concatenation runs 15 down to 0
  localparam logic [15:0][11:0] DUCK_PALETTE = {
    12'h000, 12'hA01, 12'h000, 12'h000,   // 15..12
    12'h000, 12'h000, 12'h000, 12'h000,   // 11..8
    12'h000, 12'hAEA, 12'h050, 12'hF76,   // 7..4
    12'h000, 12'hFFF, 12'h000, 12'h000    // 3..0
  };

  function automatic rgb12_t duck_lookup(input logic [3:0] idx);
    return rgb12_t'(DUCK_PALETTE[idx]);
  endfunction

endpackage

// File: rtl/duck_rr_pick.sv
// Combinational round-robin picker: first asserted request at or above
// i_ptr, wrapping modulo N_REQ.
module duck_rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [ID_W-1:0]  o_idx,
  output logic             o_any
);

  always_comb begin
    logic [ID_W-1:0] w_cand;
    logic            w_found;
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      w_cand = ID_W'((32'(i_ptr) + k) % N_REQ);
      if (!w_found && i_req[w_cand]) begin
        w_found         = 1'b1;
        o_grant[w_cand] = 1'b1;
        o_idx           = w_cand;
      end
    end
    o_any = w_found;
  end

endmodule

// File: rtl/duck_palette_arbiter.sv
// Round-robin share of the duck palette lookup among N_REQ pixel pipelines,
// followed by a two-stage registered lookup with full-rate backpressure.
module duck_palette_arbiter
  import duck_pkg::*;
#(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned IDX_W        = 4,
  parameter int unsigned TRANSP_INDEX = DUCK_TRANSP_INDEX
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*IDX_W-1:0]     req_index,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(N_REQ)-1:0]   rsp_id,
  output logic [3:0]                 rsp_red,
  output logic [3:0]                 rsp_green,
  output logic [3:0]                 rsp_blue,
  output logic                       rsp_transp
);

  localparam int unsigned ID_W = $clog2(N_REQ);

  logic [ID_W-1:0]  r_rr_ptr;
  logic             r_s1_valid;
  logic [IDX_W-1:0] r_s1_index;
  logic [ID_W-1:0]  r_s1_id;
  logic             r_rsp_valid;
  rgb12_t           r_rsp_rgb;
  logic [ID_W-1:0]  r_rsp_id;
  logic             r_rsp_transp;

  logic [N_REQ-1:0] w_grant;
  logic [ID_W-1:0]  w_idx;
  logic             w_any;
  logic             w_adv1;
  logic             w_adv2;
  logic [IDX_W-1:0] w_sel_index;

  duck_rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign w_adv2 = !r_rsp_valid || rsp_ready;
  assign w_adv1 = !r_s1_valid || w_adv2;
  // Gating with Reset_n keeps req_ready low while reset is held
  assign req_ready = w_grant & {N_REQ{w_adv1 & Reset_n}};

  always_comb begin
    w_sel_index = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (w_grant[k]) w_sel_index = req_index[k*IDX_W +: IDX_W];
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_rr_ptr     <= '0;
      r_s1_valid   <= 1'b0;
      r_s1_index   <= '0;
      r_s1_id      <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_rgb    <= '0;
      r_rsp_id     <= '0;
      r_rsp_transp <= 1'b0;
    end else begin
      if (w_adv1) begin
        r_s1_valid <= w_any;
        r_s1_index <= w_sel_index;
        r_s1_id    <= w_idx;
        if (w_any) r_rr_ptr <= (w_idx == ID_W'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
      end
      if (w_adv2) begin
        r_rsp_valid  <= r_s1_valid;
        r_rsp_rgb    <= duck_lookup(r_s1_index);
        r_rsp_id     <= r_s1_id;
        r_rsp_transp <= (r_s1_index == IDX_W'(TRANSP_INDEX));
      end
    end
  end

  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_red    = r_rsp_rgb.red;
  assign rsp_green  = r_rsp_rgb.green;
  assign rsp_blue   = r_rsp_rgb.blue;
  assign rsp_transp = r_rsp_transp;

endmodule

// File: tb/tb_duck_palette_arbiter.sv
// Bench for duck_palette_arbiter: directed scenarios plus random traffic,
// checked against a queue-based model of the arbiter and two-entry pipeline.
module tb_duck_palette_arbiter;

  localparam int N = 4;

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic [N-1:0]  req_valid;
  logic [N*4-1:0] req_index;
  logic [N-1:0]  req_ready;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [1:0]    rsp_id;
  logic [3:0]    rsp_red, rsp_green, rsp_blue;
  logic          rsp_transp;

  duck_palette_arbiter #(
    .N_REQ        (N),
    .IDX_W        (4),
    .TRANSP_INDEX (6)
  ) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .req_valid  (req_valid),
    .req_index  (req_index),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_red    (rsp_red),
    .rsp_green  (rsp_green),
    .rsp_blue   (rsp_blue),
    .rsp_transp (rsp_transp)
  );

  always #5 Clk = ~Clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int palette_ref(input int i);
    case (i)
      2:       return 'hFFF;
      4:       return 'hF76;
      5:       return 'h050;
      6:       return 'hAEA;
      14:      return 'hA01;
      default: return 'h000;
    endcase
  endfunction

  typedef struct { int id; int idx; int acc; } item_t;
  typedef struct { int id; int idx; } script_t;

  item_t   pipe[$];
  script_t script_q[$];
  int      ptr   = 0;
  int      edges = 0;
  int      gen_mode = 0;   // 0 script only, 1 random, 2 all requesters always on
  bit      pend[N];
  int      pidx[N];

  task automatic refill_and_drive();
    for (int i = 0; i < N; i++) begin
      if (!pend[i]) begin
        if (script_q.size() > 0 && script_q[0].id == i) begin
          pend[i] = 1'b1;
          pidx[i] = script_q[0].idx;
          void'(script_q.pop_front());
        end else if (gen_mode == 2 || (gen_mode == 1 && $urandom_range(1, 0) == 1)) begin
          pend[i] = 1'b1;
          pidx[i] = int'($urandom_range(15, 0));
        end
      end
      req_valid[i]         = pend[i];
      req_index[i*4 +: 4]  = 4'(pidx[i]);
    end
  endtask

  // Entered and left 1 time unit after a rising edge.
  task automatic step(input bit rdy);
    bit vis, can;
    int g, c;
    refill_and_drive();
    rsp_ready = rdy;
    #3;
    vis = pipe.size() > 0 && (edges - pipe[0].acc) >= 1;
    check_eq("rsp_valid", 32'(rsp_valid), 32'(vis));
    if (vis) begin
      check_eq("rsp_id", 32'(rsp_id), pipe[0].id);
      check_eq("rsp_rgb", {20'd0, rsp_red, rsp_green, rsp_blue}, palette_ref(pipe[0].idx));
      check_eq("rsp_transp", 32'(rsp_transp), 32'(pipe[0].idx == 6));
    end
    can = pipe.size() < 2 || (vis && rdy);
    g = -1;
    for (int k = 0; k < N; k++) begin
      c = (ptr + k) % N;
      if (g < 0 && pend[c]) g = c;
    end
    check_eq("req_ready", 32'(req_ready), (can && g >= 0) ? (1 << g) : 0);
    @(posedge Clk);
    #1;
    edges++;
    if (vis && rdy) void'(pipe.pop_front());
    if (can && g >= 0) begin
      pipe.push_back('{id: g, idx: pidx[g], acc: edges});
      ptr = (g + 1) % N;
      pend[g] = 1'b0;
    end
  endtask

  task automatic drain();
    gen_mode = 0;
    for (int i = 0; i < 12; i++) step(1'b1);
  endtask

  initial begin
    rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b1;
      pidx[i] = i + 3;
    end
    refill_and_drive();
    repeat (3) @(posedge Clk);
    #1;
    check_eq("reset_rsp_valid", 32'(rsp_valid), 0);
    check_eq("reset_req_ready", 32'(req_ready), 0);
    check_eq("reset_rsp_id", 32'(rsp_id), 0);
    check_eq("reset_rgb", {20'd0, rsp_red, rsp_green, rsp_blue}, 0);
    check_eq("reset_transp", 32'(rsp_transp), 0);
    Reset_n = 1'b1;
    #1;
    check_eq("first_grant", 32'(req_ready), 32'h1);
    drain();

    script_q.push_back('{id: 2, idx: 4});
    for (int i = 0; i < 4; i++) step(1'b1);

    gen_mode = 2;
    for (int i = 0; i < 20; i++) step(1'b1);
    drain();

    script_q.push_back('{id: 0, idx: 6});
    script_q.push_back('{id: 3, idx: 9});
    for (int i = 0; i < 5; i++) step(1'b1);

    script_q.push_back('{id: 1, idx: 2});
    script_q.push_back('{id: 1, idx: 5});
    script_q.push_back('{id: 1, idx: 14});
    step(1'b1);
    for (int i = 0; i < 5; i++) step(1'b0);
    for (int i = 0; i < 6; i++) step(1'b1);

    gen_mode = 1;
    for (int i = 0; i < 300; i++) step($urandom_range(3, 0) != 0);

    step(1'b0);
    step(1'b0);
    check_eq("pre_reset_valid", 32'(rsp_valid), 1);
    Reset_n = 1'b0;
    #1;
    check_eq("async_rst_valid", 32'(rsp_valid), 0);
    check_eq("async_rst_ready", 32'(req_ready), 0);
    pipe.delete();
    ptr = 0;
    @(posedge Clk);
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    for (int i = 0; i < 150; i++) step($urandom_range(3, 0) != 0);
    drain();
    check_eq("final_empty", 32'(rsp_valid), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
